// File: rtl/cmul_round_pipe.sv
// cmul_round_pipe: 3-stage pipelined complex multiplier (data x twiddle) with frame index/SOF tracking.
// Build option: define CMUL_ROUND_EN for round-half-up output; otherwise the output is truncated (floor).
module cmul_round_pipe #(
  parameter int DL     = 10,
  parameter int TL     = 10,
  parameter int N_LOG2 = 6,
  localparam int OL    = DL + 2
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iEN,
  input  logic              iCLR,
  input  logic              iVALID,
  input  logic [DL-1:0]     iDATA_RE,
  input  logic [DL-1:0]     iDATA_IM,
  input  logic [TL-1:0]     iTW_RE,
  input  logic [TL-1:0]     iTW_IM,
  output logic              oVALID,
  output logic [OL-1:0]     oDATA_RE,
  output logic [OL-1:0]     oDATA_IM,
  output logic [N_LOG2-1:0] oIDX,
  output logic              oSOF
);

  localparam int MW = DL + TL;
  localparam int PW = DL + TL + 1;
  localparam int SH = TL - 2;

`ifdef CMUL_ROUND_EN
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (TL - 3);
`else
  localparam logic signed [PW-1:0] RND = {PW{1'b0}};
`endif
  localparam logic [N_LOG2-1:0] IDX_ONE = {{(N_LOG2-1){1'b0}}, 1'b1};

  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, sof_q, sof_d;
  logic signed [DL-1:0]     ar_q, ar_d, ai_q, ai_d;
  logic signed [TL-1:0]     br_q, br_d, bi_q, bi_d;
  logic signed [MW-1:0]     p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic signed [OL-1:0]     re_q, re_d, im_q, im_d;
  logic [N_LOG2-1:0]        idx_q, idx_d;
  logic signed [PW-1:0]     pr_s, pi_s, pr_rnd_s, pi_rnd_s;
  logic                     unused_bits_s;

  // Datapath: operand capture, partial products, combine/round/select; advances only on iEN.
  always_comb begin
    ar_d   = ar_q;
    ai_d   = ai_q;
    br_d   = br_q;
    bi_d   = bi_q;
    p_rr_d = p_rr_q;
    p_ii_d = p_ii_q;
    p_ri_d = p_ri_q;
    p_ir_d = p_ir_q;
    re_d   = re_q;
    im_d   = im_q;
    pr_s     = PW'(p_rr_q) - PW'(p_ii_q);
    pi_s     = PW'(p_ri_q) + PW'(p_ir_q);
    pr_rnd_s = pr_s + RND;
    pi_rnd_s = pi_s + RND;
    // Top bit and fraction bits are dropped; the selected field cannot overflow for |tw| <= 1.0.
    unused_bits_s = ^{pr_rnd_s[PW-1], pr_rnd_s[SH-1:0], pi_rnd_s[PW-1], pi_rnd_s[SH-1:0]};
    if (iEN) begin
      ar_d   = iDATA_RE;
      ai_d   = iDATA_IM;
      br_d   = iTW_RE;
      bi_d   = iTW_IM;
      p_rr_d = MW'(ar_q) * MW'(br_q);
      p_ii_d = MW'(ai_q) * MW'(bi_q);
      p_ri_d = MW'(ar_q) * MW'(bi_q);
      p_ir_d = MW'(ai_q) * MW'(br_q);
      re_d   = pr_rnd_s[SH+OL-1:SH];
      im_d   = pi_rnd_s[SH+OL-1:SH];
    end else begin
      ar_d   = ar_q;
      ai_d   = ai_q;
      br_d   = br_q;
      bi_d   = bi_q;
      p_rr_d = p_rr_q;
      p_ii_d = p_ii_q;
      p_ri_d = p_ri_q;
      p_ir_d = p_ir_q;
      re_d   = re_q;
      im_d   = im_q;
    end
  end

  // Control: valid pipe and output index; iCLR outranks the stall and the incoming valid.
  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    v3_d  = v3_q;
    idx_d = idx_q;
    if (iCLR) begin
      v1_d  = 1'b0;
      v2_d  = 1'b0;
      v3_d  = 1'b0;
      idx_d = {N_LOG2{1'b0}};
    end else if (iEN) begin
      v1_d = iVALID;
      v2_d = v1_q;
      v3_d = v2_q;
      if (v3_q) begin
        idx_d = idx_q + IDX_ONE;
      end else begin
        idx_d = idx_q;
      end
    end else begin
      v1_d  = v1_q;
      v2_d  = v2_q;
      v3_d  = v3_q;
      idx_d = idx_q;
    end
    sof_d = v3_d & (idx_d == {N_LOG2{1'b0}});
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      sof_q  <= 1'b0;
      idx_q  <= {N_LOG2{1'b0}};
      ar_q   <= {DL{1'b0}};
      ai_q   <= {DL{1'b0}};
      br_q   <= {TL{1'b0}};
      bi_q   <= {TL{1'b0}};
      p_rr_q <= {MW{1'b0}};
      p_ii_q <= {MW{1'b0}};
      p_ri_q <= {MW{1'b0}};
      p_ir_q <= {MW{1'b0}};
      re_q   <= {OL{1'b0}};
      im_q   <= {OL{1'b0}};
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      sof_q  <= sof_d;
      idx_q  <= idx_d;
      ar_q   <= ar_d;
      ai_q   <= ai_d;
      br_q   <= br_d;
      bi_q   <= bi_d;
      p_rr_q <= p_rr_d;
      p_ii_q <= p_ii_d;
      p_ri_q <= p_ri_d;
      p_ir_q <= p_ir_d;
      re_q   <= re_d;
      im_q   <= im_d;
    end
  end

  assign oVALID   = v3_q;
  assign oDATA_RE = re_q;
  assign oDATA_IM = im_q;
  assign oIDX     = idx_q;
  assign oSOF     = sof_q;

endmodule

// File: tb/tb_cmul_round_pipe.sv
// Self-checking bench for cmul_round_pipe: behavioural queue model plus directed literal cases.
module tb_cmul_round_pipe;
  localparam int DL = 10;
  localparam int TL = 10;
  localparam int OL = 12;
  localparam int NL = 3;

  logic          iCLK = 1'b0;
  logic          iRSTn = 1'b0;
  logic          iEN = 1'b0;
  logic          iCLR = 1'b0;
  logic          iVALID = 1'b0;
  logic [DL-1:0] iDATA_RE = '0;
  logic [DL-1:0] iDATA_IM = '0;
  logic [TL-1:0] iTW_RE = '0;
  logic [TL-1:0] iTW_IM = '0;
  logic          oVALID, oSOF;
  logic [OL-1:0] oDATA_RE, oDATA_IM;
  logic [NL-1:0] oIDX;

  cmul_round_pipe #(.DL(DL), .TL(TL), .N_LOG2(NL)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iCLR(iCLR), .iVALID(iVALID),
    .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM), .iTW_RE(iTW_RE), .iTW_IM(iTW_IM),
    .oVALID(oVALID), .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM), .oIDX(oIDX), .oSOF(oSOF)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {int edge_no; int re; int im;} exp_t;
  exp_t q[$];
  int   enc = 0;
  int   m_idx = 0;
  int   acc_idx[$];
  int   n_pass = 0;
  int   n_tot = 0;
  bit   ev_c;

  task automatic chk(input string name, input int got, input int want);
    n_tot++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Complex product scaled by 2^(TL-2), floor after optional half-LSB bias.
  function automatic void cmodel(input int ar, input int ai, input int br, input int bi,
                                 output int re, output int im);
    longint pr, pi, rnd;
`ifdef CMUL_ROUND_EN
    rnd = 64'sd128;
`else
    rnd = 64'sd0;
`endif
    pr = longint'(ar) * br - longint'(ai) * bi;
    pi = longint'(ar) * bi + longint'(ai) * br;
    re = int'((pr + rnd) >>> (TL - 2));
    im = int'((pi + rnd) >>> (TL - 2));
  endfunction

  function automatic int rd();
    return int'($urandom_range(1023)) - 512;
  endfunction

  function automatic int rt();
    return int'($urandom_range(512)) - 256;
  endfunction

  // Model: each sample captured on enabled edge k is on the output after enabled edge k+2.
  initial forever begin
    exp_t e;
    @(posedge iCLK or negedge iRSTn);
    if (!iRSTn) begin
      q.delete(); enc = 0; m_idx = 0;
    end else if (iCLR) begin
      q.delete(); m_idx = 0;
    end else if (iEN) begin
      if (q.size() > 0 && q[0].edge_no == enc - 2) begin
        void'(q.pop_front());
        m_idx = (m_idx + 1) % (1 << NL);
      end
      enc++;
      if (iVALID) begin
        cmodel(int'($signed(iDATA_RE)), int'($signed(iDATA_IM)),
               int'($signed(iTW_RE)), int'($signed(iTW_IM)), e.re, e.im);
        e.edge_no = enc;
        q.push_back(e);
      end
    end
  end

  // Compare on every falling edge.
  initial forever begin
    @(negedge iCLK);
    if (!iRSTn) begin
      chk("rst_valid", int'(oVALID), 0);
      chk("rst_re", int'(oDATA_RE), 0);
      chk("rst_im", int'(oDATA_IM), 0);
      chk("rst_idx", int'(oIDX), 0);
      chk("rst_sof", int'(oSOF), 0);
    end else begin
      ev_c = (q.size() > 0) && (q[0].edge_no == enc - 2);
      chk("valid", int'(oVALID), int'(ev_c));
      if (ev_c && oVALID) begin
        chk("data_re", int'($signed(oDATA_RE)), q[0].re);
        chk("data_im", int'($signed(oDATA_IM)), q[0].im);
        chk("idx", int'(oIDX), m_idx);
        chk("sof", int'(oSOF), (m_idx == 0) ? 1 : 0);
      end else begin
        chk("sof_idle", int'(oSOF), 0);
      end
      if (oVALID && iEN && !iCLR) acc_idx.push_back(int'(oIDX));
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic set_in(input bit v, input int ar, input int ai, input int br, input int bi);
    iVALID   = v;
    iDATA_RE = DL'(ar);
    iDATA_IM = DL'(ai);
    iTW_RE   = TL'(br);
    iTW_IM   = TL'(bi);
  endtask

  task automatic directed(input string nm, input int ar, input int ai, input int br, input int bi,
                          input int wre, input int wim, input int widx);
    int lat;
    bit got;
    set_in(1'b1, ar, ai, br, bi);
    tick();
    set_in(1'b0, 0, 0, 0, 0);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge iCLK);
      if (oVALID) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk({nm, "_seen"}, int'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, lat, 2);
      chk({nm, "_re"}, int'($signed(oDATA_RE)), wre);
      chk({nm, "_im"}, int'($signed(oDATA_IM)), wim);
      chk({nm, "_idx"}, int'(oIDX), widx);
      chk({nm, "_sof"}, int'(oSOF), (widx == 0) ? 1 : 0);
    end
  endtask

  int mr, mi;
  int exp_seq[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int rnd_pos, rnd_neg, rnd_pos_re, rnd_neg_re;

  initial begin
`ifdef CMUL_ROUND_EN
    rnd_pos_re = 2; rnd_neg_re = -1;
`else
    rnd_pos_re = 1; rnd_neg_re = -2;
`endif
    cmodel(100, -37, 256, 0, mr, mi);   chk("model_id_re", mr, 100);  chk("model_id_im", mi, -37);
    cmodel(100, -37, 0, 256, mr, mi);   chk("model_j_re", mr, 37);    chk("model_j_im", mi, 100);
    cmodel(-512, -512, -256, 256, mr, mi); chk("model_corner_re", mr, 1024); chk("model_corner_im", mi, 0);
    cmodel(3, 0, 128, 0, mr, mi);       chk("model_rnd_pos", mr, rnd_pos_re);
    cmodel(-3, 0, 128, 0, mr, mi);      chk("model_rnd_neg", mr, rnd_neg_re);

    iEN = 1'b1;
    repeat (3) tick();
    chk("reset_valid", int'(oVALID), 0);
    chk("reset_idx", int'(oIDX), 0);
    iRSTn = 1'b1;
    tick();

    directed("identity", 100, -37, 256, 0, 100, -37, 0);
    directed("rot_j", 100, -37, 0, 256, 37, 100, 1);
    directed("corner", -512, -512, -256, 256, 1024, 0, 2);
    directed("rnd_pos", 3, 0, 128, 0, rnd_pos_re, 0, 3);
    directed("rnd_neg", -3, 0, 128, 0, rnd_neg_re, 0, 4);

    // Ten valids with one bubble: index sequence 0..7,0,1.
    iCLR = 1'b1; tick(); iCLR = 1'b0;
    acc_idx.delete();
    for (int i = 0; i < 11; i++) begin
      set_in(i != 4, rd(), rd(), rt(), rt());
      tick();
    end
    set_in(1'b0, 0, 0, 0, 0);
    repeat (5) tick();
    chk("stream_count", acc_idx.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("stream_idx", (i < acc_idx.size()) ? acc_idx[i] : -1, exp_seq[i]);

    // Two-cycle stall mid-stream; inputs offered during the stall are ignored.
    for (int i = 0; i < 8; i++) begin
      iEN = !(i == 3 || i == 4);
      set_in(1'b1, rd(), rd(), rt(), rt());
      tick();
    end
    iEN = 1'b1;
    set_in(1'b0, 0, 0, 0, 0);
    repeat (5) tick();

    // Clear with two samples in flight.
    set_in(1'b1, 5, 6, 256, 0); tick();
    set_in(1'b1, 7, 8, 256, 0); tick();
    set_in(1'b0, 0, 0, 0, 0);
    iCLR = 1'b1; tick(); iCLR = 1'b0;
    repeat (4) tick();
    directed("after_clr", 9, -9, 256, 0, 9, -9, 0);

    // Random traffic with stalls, bubbles and occasional clears.
    for (int i = 0; i < 400; i++) begin
      iEN  = ($urandom % 5) != 0;
      iCLR = ($urandom % 40) == 0;
      set_in(($urandom % 4) != 0, rd(), rd(), rt(), rt());
      tick();
    end
    iEN = 1'b1; iCLR = 1'b0;
    set_in(1'b0, 0, 0, 0, 0);
    repeat (5) tick();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, rd(), rd(), rt(), rt());
      tick();
    end
    #1 iRSTn = 1'b0;
    #1;
    chk("async_rst_valid", int'(oVALID), 0);
    chk("async_rst_re", int'(oDATA_RE), 0);
    chk("async_rst_im", int'(oDATA_IM), 0);
    chk("async_rst_idx", int'(oIDX), 0);
    chk("async_rst_sof", int'(oSOF), 0);
    set_in(1'b0, 0, 0, 0, 0);
    tick(); tick();
    iRSTn = 1'b1;
    tick();
    directed("after_rst", 100, -37, 256, 0, 100, -37, 0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
